// File: rtl/pipelined_cla_addsub.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_cla_addsub
// Description : Parametrised pipelined carry-lookahead adder/subtractor.
//               The WIDTH-bit operation is split into STAGES registered
//               segments of SEG = WIDTH/STAGES bits. Each segment is built
//               from 4-bit CLA groups whose carries come from group P/G
//               lookahead. A valid/ready handshake on both sides lets the
//               block sit between back-pressured datapath blocks.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               in_valid   - operands present
//               in_ready   - operands accepted this cycle
//               A, B       - operands (unsigned or two's complement)
//               cin        - carry-in (ignored when sub=1)
//               sub        - 0: A+B+cin, 1: A-B
//               out_valid  - result valid
//               out_ready  - downstream accepts result
//               S          - sum/difference (mod 2^WIDTH)
//               cout       - carry-out of MSB (no-borrow flag for sub)
//               ovf        - signed overflow
//               zero       - S == 0
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_cla_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / 4;
  localparam int LAST = STAGES - 1;

  if ((STAGES < 1) || (WIDTH % (4 * STAGES) != 0)) begin : g_param_check
    $error("pipelined_cla_addsub: WIDTH must be a multiple of 4*STAGES");
  end

  // One SEG-bit carry-lookahead segment.
  // Returns {carry into segment MSB, carry out of segment, sum bits}.
  function automatic logic [SEG+1:0] cla_seg(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           ci);
    logic [SEG-1:0]  w_p;
    logic [SEG-1:0]  w_g;
    logic [SEG:0]    w_c;
    logic [NGRP-1:0] w_gp;
    logic [NGRP-1:0] w_gg;
    logic [NGRP:0]   w_gc;
    logic            w_acc;
    logic            w_pp;
    logic            w_cg;
    w_p = a ^ b;
    w_g = a & b;
    for (int j = 0; j < NGRP; j++) begin
      w_gp[j] = &w_p[4*j +: 4];
      w_gg[j] = w_g[4*j+3]
              | (w_p[4*j+3] & w_g[4*j+2])
              | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
              | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
    end
    // Group carries in flat sum-of-products form: each one is an OR of
    // generate terms masked by the propagates above them, so no carry
    // depends on the previous group's carry.
    w_gc[0] = ci;
    for (int j = 1; j <= NGRP; j++) begin
      w_acc = 1'b0;
      w_pp  = 1'b1;
      for (int i = j - 1; i >= 0; i--) begin
        w_acc = w_acc | (w_gg[i] & w_pp);
        w_pp  = w_pp & w_gp[i];
      end
      w_gc[j] = w_acc | (ci & w_pp);
    end
    // Bit carries inside each 4-bit group, again in lookahead form.
    for (int j = 0; j < NGRP; j++) begin
      w_cg         = w_gc[j];
      w_c[4*j]     = w_cg;
      w_c[4*j + 1] = w_g[4*j] | (w_p[4*j] & w_cg);
      w_c[4*j + 2] = w_g[4*j+1] | (w_p[4*j+1] & w_g[4*j])
                   | (w_p[4*j+1] & w_p[4*j] & w_cg);
      w_c[4*j + 3] = w_g[4*j+2] | (w_p[4*j+2] & w_g[4*j+1])
                   | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                   | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & w_cg);
    end
    w_c[SEG] = w_gc[NGRP];
    return {w_c[SEG-1], w_c[SEG], w_p ^ w_c[SEG-1:0]};
  endfunction

  // Stage registers. Operands are carried whole; each stage only consumes
  // its own slice, and the lower sum bits accumulate as the op moves down.
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;
  logic              r_ovf;
  logic              r_zero;

  logic [WIDTH-1:0]  w_a_src   [STAGES];
  logic [WIDTH-1:0]  w_b_src   [STAGES];
  logic [WIDTH-1:0]  w_s_src   [STAGES];
  logic [WIDTH-1:0]  w_sum_nxt [STAGES];
  logic [SEG+1:0]    w_res     [STAGES];
  logic [STAGES-1:0] w_c_src;
  logic [STAGES-1:0] w_v_src;
  logic [STAGES:0]   w_go;
  logic              w_ovf_nxt;
  logic              w_zero_nxt;

  always_comb begin
    // Subtraction is folded in before the first register: invert B and
    // force the carry-in, so every later stage is a plain adder.
    w_a_src[0] = A;
    w_b_src[0] = sub ? ~B : B;
    w_c_src[0] = sub | cin;
    w_s_src[0] = '0;
    w_v_src[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_a_src[k] = r_a[k-1];
      w_b_src[k] = r_b[k-1];
      w_s_src[k] = r_sum[k-1];
      w_c_src[k] = r_c[k-1];
      w_v_src[k] = r_v[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_res[k]     = cla_seg(w_a_src[k][k*SEG +: SEG],
                             w_b_src[k][k*SEG +: SEG],
                             w_c_src[k]);
      w_sum_nxt[k] = w_s_src[k];
      w_sum_nxt[k][k*SEG +: SEG] = w_res[k][SEG-1:0];
    end
    // A stage may load when it is empty or its contents move on; the chain
    // is combinational from out_ready back to in_ready.
    w_go[STAGES] = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      w_go[k] = !r_v[k] || w_go[k+1];
    end
    w_ovf_nxt  = w_res[LAST][SEG+1] ^ w_res[LAST][SEG];
    w_zero_nxt = (w_sum_nxt[LAST] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v    <= '0;
      r_c    <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_go[k]) begin
          r_v[k] <= w_v_src[k];
          // Data only moves with a valid op, so a bubble leaves the
          // previous result visible rather than loading garbage.
          if (w_v_src[k]) begin
            r_a[k]   <= w_a_src[k];
            r_b[k]   <= w_b_src[k];
            r_sum[k] <= w_sum_nxt[k];
            r_c[k]   <= w_res[k][SEG];
          end
        end
      end
      if (w_go[LAST] && w_v_src[LAST]) begin
        r_ovf  <= w_ovf_nxt;
        r_zero <= w_zero_nxt;
      end
    end
  end

  assign in_ready  = w_go[0];
  assign out_valid = r_v[LAST];
  assign S         = r_sum[LAST];
  assign cout      = r_c[LAST];
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_cla_addsub
// Description : Scoreboard bench for pipelined_cla_addsub. Accepted ops push
//               an arithmetic-model result; a monitor compares whenever the
//               DUT presents a result and tracks pipeline occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_cla_addsub;

  localparam int W  = 16;
  localparam int ST = 2;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
  } res_t;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] A         = '0;
  logic [W-1:0] B         = '0;
  logic         cin       = 1'b0;
  logic         sub       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] S;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         done      = 1'b0;

  res_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   occ    = 0;

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(W), .STAGES(ST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  // Plain integer arithmetic reference.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s_in);
    longint ua, ub, sa, sb, r, sr, lim;
    res_t   x;
    lim = longint'(1) << W;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = a[W-1] ? ua - lim : ua;
    sb  = b[W-1] ? ub - lim : ub;
    if (s_in) begin
      r    = ua - ub;
      x.co = (ua >= ub);
      sr   = sa - sb;
    end else begin
      r    = ua + ub + longint'(c);
      x.co = (r >= lim);
      sr   = sa + sb + longint'(c);
    end
    x.s  = W'(r);
    x.ov = (sr >= lim / 2) || (sr < -(lim / 2));
    x.z  = (x.s == '0);
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: inputs change only just after a rising edge, so values seen
  // here are the ones the next edge will act on.
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      q.delete();
      occ = 0;
    end else begin
      chk("in_ready", in_ready, (occ < ST) || out_ready);
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got valid S=%0h expected no result", S);
        end else begin
          e = q[0];
          chk("S", S, e.s);
          chk("cout", cout, e.co);
          chk("ovf", ovf, e.ov);
          chk("zero", zero, e.z);
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(A, B, cin, sub));
      occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic s);
    int n;
    A = a; B = b; cin = c; sub = s; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (occ != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Single op into an empty pipe; counts edges until the result shows.
  task automatic probe(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s);
    int n;
    drain();
    send(a, b, c, s);
    n = 1;
    while (!out_valid && n <= 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, ST);
  endtask

  initial begin
    logic [W-1:0] vals [5];
    logic [5:0]   pat;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_S", S, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", in_ready, 1);

    // Directed arithmetic, each with a latency probe
    probe(W'(414),   W'(1036),  1'b0, 1'b0);
    probe(W'(32768), W'(32768), 1'b0, 1'b0);
    probe(W'(65535), W'(65535), 1'b1, 1'b0);
    probe(W'(5045),  W'(45042), 1'b0, 1'b1);
    probe(W'(100),   W'(100),   1'b0, 1'b1);
    probe(W'(32767), W'(65535), 1'b1, 1'b1);
    drain();

    // Back-pressure: 6 back-to-back ops, out_ready 1,0,0,1,0,1
    pat = 6'b101001;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        for (int i = 0; i < 6; i++) begin
          out_ready = pat[i];
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Fill the pipe while the output is blocked; in_ready must drop
    fork
      begin
        for (int i = 0; i < ST + 1; i++)
          send(W'($urandom), W'($urandom), 1'b0, 1'b0);
      end
      begin
        out_ready = 1'b0;
        repeat (ST + 4) begin
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two ops in flight
    send(W'(1234), W'(4321), 1'b0, 1'b0);
    send(W'(7),    W'(9),    1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_S", S, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_zero", zero, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", in_ready, 1);
    probe(W'(20), W'(22), 1'b1, 1'b0);
    drain();

    // Corner patterns
    vals[0] = '0;
    vals[1] = '1;
    vals[2] = {1'b1, {(W-1){1'b0}}};
    vals[3] = {(W/4){4'hA}};
    vals[4] = {(W/4){4'h5}};
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int s = 0; s < 2; s++)
          send(vals[i], vals[j], 1'($urandom_range(0, 1)), 1'(s));
    drain();

    // Random ops, random gaps and random back-pressure
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the combinational 16-bit CLA.
- Splits the WIDTH-bit operation into STAGES registered carry-lookahead segments.
- Each segment is built from 4-bit CLA groups with group P/G lookahead.
- Valid/ready handshake on both sides, so it can sit between back-pressured datapath blocks in the ALU.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of 4*STAGES.
- STAGES, 2, number of pipeline segments; equals latency in cycles; 1..WIDTH/4.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present this cycle.
- in_ready  output  1  block accepts operands this cycle.
- A  input  WIDTH  operand A, unsigned or two's complement.
- B  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: S=A+B+cin; 1: S=A-B (A + ~B + 1).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- S  output  WIDTH  sum/difference.
- cout  output  1  carry-out of MSB. For sub this is the no-borrow flag: 1 when A>=B unsigned.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  S == 0.

Behaviour:
- Reset (rst_n=0, async):
  - All stage valid bits clear and all data registers cleared.
  - Outputs: out_valid=0, S=0, cout=0, ovf=0, zero=0.
  - in_ready=1 once rst_n deasserts.
  - Reset mid-operation discards all in-flight results; none appears after release.
- Accept and emit:
  - Transfer in: in_valid && in_ready at a rising edge.
  - Transfer out: out_valid && out_ready.
- Segment computation. Let SEG = WIDTH/STAGES.
  - Stage k (k=0..STAGES-1) computes bits [k*SEG +: SEG] using SEG/4 4-bit CLA groups.
  - Within a stage, group carries come from group P/G lookahead, not ripple between groups.
  - Each stage registers:
    - its partial sum;
    - the carry into the next segment;
    - the not-yet-added upper operand bits;
    - the already computed lower sum bits.
  - With sub=1, B is inverted and carry-in forced to 1 at stage 0, before the first register.
- Latency: a result accepted at edge t has out_valid=1 after edge t+STAGES-1, i.e. visible in the cycle after the final stage registers. Registered stage count equals STAGES.
- Throughput: one operation per cycle when out_ready=1.
- Back-pressure:
  - Each stage has a valid bit.
  - Stage i advances when its successor is empty or also advancing.
  - The last stage advances when out_ready=1 or out_valid=0.
  - in_ready = !v0 || advance0; this is combinational from out_ready through the stall chain.
  - While stalled, all outputs hold stable. No result is dropped or duplicated; results emerge in acceptance order.
- Output flags cout/ovf/zero are registered alongside S in the last stage, never computed combinationally from S.
- Wrap-around: results are modulo 2^WIDTH. Carry beyond the MSB appears only on cout.
- Simultaneous accept and emit on a full pipeline (out_ready=1, in_valid=1) is legal and sustains full throughput.
- Illegal parameter combination (WIDTH % (4*STAGES) != 0): generate-time error.

Test Plan:
- Add basics (defaults): A=414, B=1036, cin=0, sub=0 → after 2 cycles S=1450, cout=0, ovf=0, zero=0.
- Carry chain:
  - A=32768, B=32768 → S=0, cout=1, ovf=1, zero=1.
  - A=65535, B=65535, cin=1 → S=65535, cout=1, ovf=0.
- Subtract:
  - A=5045, B=45042, sub=1 → S=25539, cout=0 (borrow), ovf=0.
  - A=100, B=100, sub=1 → S=0, cout=1, zero=1.
  - A=32767, B=65535 (−1), sub=1 → S=32768, ovf=1.
- Back-pressure:
  - Stream 6 back-to-back ops with out_ready toggling 1,0,0,1,0,1.
  - Required: in_ready drops while both stages are full; S held stable during stalls; all 6 results appear once, in order.
- Reset mid-stream: assert rst_n=0 asynchronously with 2 ops in flight → out_valid=0 and S=0 immediately; no stale result after release; the first new op completes after STAGES cycles.
- Parametric sweep: WIDTH=32/STAGES=4 and WIDTH=8/STAGES=1 against a reference model. Cover 1000 random ops plus corners 0, max, 0x80..0, and alternating 0xAA/0x55 patterns. Check S/cout/ovf/zero exactly and latency = STAGES.
